// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image and writes it
// word by word into instruction BRAM, stalling the core until the image is complete.
module imem_boot_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] mem_w_addr,
   output logic [DATA_WIDTH-1:0] mem_w_dat,
   output logic                  mem_w_enb,
   output logic [3:0]            mem_byte_enb,
   output logic                  core_stall,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_LOAD, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t                  state, state_next;
   logic [1:0]              byte_cnt;
   logic [31:0]             word_cnt;
   logic [DATA_WIDTH-1:0]   asm_word;
   logic                    accept;
   logic                    last_byte;
   logic [31:0]             len_full;
   logic [31:0]             written_next;

   assign accept       = in_valid && in_ready;
   assign last_byte    = accept && (byte_cnt == 2'd3);
   // Header shifts in from the top so the first byte lands in bits [7:0].
   assign len_full     = {in_data, word_cnt[31:8]};
   assign written_next = {16'd0, words_loaded} + 32'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN;
         S_LEN: begin
            if (last_byte) begin
               if (len_full == 32'd0)                 state_next = S_DONE;
               else if (len_full > 32'(MEM_WORDS))    state_next = S_ERROR;
               else                                   state_next = S_LOAD;
            end
         end
         S_LOAD:  if (last_byte) state_next = S_WRITE;
         S_WRITE: state_next = (written_next == word_cnt) ? S_DONE : S_LOAD;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt     <= 2'd0;
         word_cnt     <= 32'd0;
         asm_word     <= '0;
         words_loaded <= 16'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  byte_cnt     <= 2'd0;
                  word_cnt     <= 32'd0;
                  words_loaded <= 16'd0;
               end
            end
            S_LEN: begin
               if (accept) begin
                  word_cnt <= len_full;
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  asm_word <= {in_data, asm_word[DATA_WIDTH-1:8]};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_WRITE: words_loaded <= written_next[15:0];
            default: ;
         endcase
      end
   end

   assign in_ready     = (state == S_LEN) || (state == S_LOAD);
   assign mem_w_enb    = (state == S_WRITE);
   assign mem_byte_enb = mem_w_enb ? 4'hF : 4'h0;
   assign mem_w_addr   = mem_w_enb ? ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({words_loaded, 2'b00})
                                   : '0;
   assign mem_w_dat    = mem_w_enb ? asm_word : '0;
   assign core_stall   = (state != S_DONE);
   assign busy         = (state == S_LEN) || (state == S_LOAD) || (state == S_WRITE);
   assign done         = (state == S_DONE);
   assign error        = (state == S_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives byte images with random gaps and checks every
// BRAM write against a queue of expected (address, word) pairs built from the image.
module tb_imem_boot_loader;

   localparam int MEM_WORDS = 1024;
   localparam logic [31:0] BASE = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [31:0] mem_w_addr;
   logic [31:0] mem_w_dat;
   logic        mem_w_enb;
   logic [3:0]  mem_byte_enb;
   logic        core_stall, busy, done, error;
   logic [15:0] words_loaded;

   int cmp_count = 0;
   int err_count = 0;
   int wr_count  = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_dat[$];
   logic [31:0] img[$];
   logic [31:0] mon_a, mon_d;

   imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat),
      .mem_w_enb(mem_w_enb), .mem_byte_enb(mem_byte_enb), .core_stall(core_stall),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmp_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Every write must match the next expected (addr, data); idle bus must read zero.
   always @(negedge clk) begin
      if (rst) begin
         if (mem_w_enb) begin
            wr_count++;
            if (exp_addr.size() == 0) begin
               chk("unexpected_write", 32'd1, 32'd0);
            end else begin
               mon_a = exp_addr.pop_front();
               mon_d = exp_dat.pop_front();
               chk("w_addr", mem_w_addr, mon_a);
               chk("w_dat", mem_w_dat, mon_d);
               chk("w_byte_enb", {28'd0, mem_byte_enb}, 32'hF);
               chk("ready_in_write", {31'd0, in_ready}, 32'd0);
               $display("write addr=%h data=%h", mem_w_addr, mem_w_dat);
            end
         end else begin
            chk("idle_addr", mem_w_addr, 32'd0);
            chk("idle_dat", mem_w_dat, 32'd0);
            chk("idle_byte_enb", {28'd0, mem_byte_enb}, 32'd0);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int t = 0;
      int gap;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   // Sends header n and, for a legal n, the words in img[]; queues expected writes.
   task automatic load_image(input logic [31:0] n, input int gap_max, input bit do_start);
      if (do_start) pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gap_max);
      if (n != 0 && n <= MEM_WORDS) begin
         for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_dat.push_back(img[i]);
            for (int k = 0; k < 4; k++) send_byte(8'(img[i] >> (8 * k)), gap_max);
         end
      end
      in_valid = 1'b0;
      for (int t = 0; t < 100 && !done && !error; t++) @(negedge clk);
   endtask

   task automatic check_done(input string tag, input logic [31:0] n);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_stall"}, {31'd0, core_stall}, 32'd0);
      chk({tag, "_words"}, {16'd0, words_loaded}, n);
      chk({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
      $display("load %s n=%0d done=%b words=%0d", tag, n, done, words_loaded);
   endtask

   task automatic spec_image();
      img.delete();
      img.push_back(32'h00A00513);
      img.push_back(32'h00500593);
   endtask

   task automatic rand_image(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
   endtask

   initial begin
      int wr_before;
      logic [31:0] n;

      #2;
      chk("rst_stall", {31'd0, core_stall}, 32'd1);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_enb", {31'd0, mem_w_enb}, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Idle with no start: stalled, never ready, never writes.
      repeat (100) @(negedge clk);
      chk("idle_stall", {31'd0, core_stall}, 32'd1);
      chk("idle_ready", {31'd0, in_ready}, 32'd0);
      chk("idle_writes", 32'(wr_count), 32'd0);

      spec_image();
      load_image(32'd2, 0, 1'b1);
      check_done("b2b", 32'd2);

      // Empty image: DONE right after the 4th header byte, no writes.
      wr_before = wr_count;
      pulse_start();
      chk("reload_stall", {31'd0, core_stall}, 32'd1);
      for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
      in_valid = 1'b0;
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_stall", {31'd0, core_stall}, 32'd0);
      chk("zero_writes", 32'(wr_count - wr_before), 32'd0);

      // Bytes offered in DONE are never acknowledged.
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("done_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;

      // Oversized header goes to ERROR and refuses bytes.
      load_image(32'(MEM_WORDS + 1), 0, 1'b1);
      chk("err_flag", {31'd0, error}, 32'd1);
      chk("err_stall", {31'd0, core_stall}, 32'd1);
      in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("err_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      pulse_start();
      chk("err_clear", {31'd0, error}, 32'd0);
      chk("err_to_len", {31'd0, busy & in_ready}, 32'd1);

      // A start while busy is ignored; the image continues from the header.
      pulse_start();
      rand_image(3);
      load_image(32'd3, 2, 1'b0);
      check_done("busy_start", 32'd3);

      spec_image();
      load_image(32'd2, 3, 1'b1);
      check_done("gaps", 32'd2);

      for (int r = 0; r < 5; r++) begin
         n = 32'($urandom_range(8, 1));
         rand_image(int'(n));
         load_image(n, $urandom_range(3, 0), 1'b1);
         check_done("rand", n);
      end

      // Reset in the middle of the first word aborts without writing.
      wr_before = wr_count;
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(8'(32'd2 >> (8 * k)), 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_stall", {31'd0, core_stall}, 32'd1);
      chk("arst_enb", {31'd0, mem_w_enb}, 32'd0);
      chk("arst_addr", mem_w_addr, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("arst_writes", 32'(wr_count - wr_before), 32'd0);
      spec_image();
      load_image(32'd2, 0, 1'b1);
      check_done("after_rst", 32'd2);

      // Largest legal image fills memory up to the last word address.
      rand_image(MEM_WORDS);
      load_image(32'(MEM_WORDS), 0, 1'b1);
      check_done("full", 32'(MEM_WORDS));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
